cache_refill_ctrl: RTL

- Downstream miss/refill controller for the 4-way LRU cache (cache_memory_lru); sits between the cache and backing memory.
- Snoops the same request bus as the cache and watches the cache hit/data outputs.
- On a read miss: fetches the word from memory, writes it into the cache via a fill port, returns it to the requester.
- All writes are write-through, posted to memory through a small write buffer.

---
 rtl/cache_pkg.sv | 22 ++
 rtl/cache_refill_ctrl_if.sv | 24 ++
 rtl/wbuf_fifo.sv | 53 +++++
 rtl/cache_refill_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types for the cache refill controller: FSM encoding, default widths
// and the write-buffer entry layout.
package cache_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_DRAIN     = 3'd2,
        ST_MISS_REQ  = 3'd3,
        ST_MISS_WAIT = 3'd4,
        ST_FILL      = 3'd5
    } state_t;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } wbuf_entry_t;

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Backing-memory port of the refill controller: request channel with
// valid/ready handshake plus a single-cycle read response.
interface cache_refill_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_data;

    modport master (
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data
    );

    modport slave (
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data
    );
endinterface

// File: rtl/wbuf_fifo.sv
// Small synchronous FIFO for posted writes. A push while full is accepted
// only when a pop retires the head in the same cycle.
module wbuf_fifo
    import cache_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = wbuf_entry_t
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  entry_t wdata,
    input  logic   pop,
    output entry_t rdata,
    output logic   full,
    output logic   empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t           store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = store[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)
                count <= count + (PTR_W+1)'(1);
            else if (do_pop && !do_push)
                count <= count - (PTR_W+1)'(1);
        end
    end

    // Payload storage needs no reset; it is only read while non-empty.
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Read-miss refill and write-through controller between the LRU cache and
// backing memory. Writes are posted through a FIFO; reads wait for it to drain.
//
//   state     | meaning
//   IDLE      | accept read (to LOOKUP) or post write into buffer
//   LOOKUP    | cache answers: hit returns data, miss counts and drains
//   DRAIN     | wait for posted writes to reach memory (RAW order)
//   MISS_REQ  | read request held on memory port until accepted
//   MISS_WAIT | wait for the read response
//   FILL      | write word into cache and return it to requester
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int WBUF_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_data,
    input  logic                req_we,
    input  logic                req_re,
    input  logic                cache_hit,
    input  logic [DATA_W-1:0]   cache_data,
    output logic                cpu_stall,
    output logic                cpu_rvalid,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                fill_we,
    output logic [ADDR_W-1:0]   fill_addr,
    output logic [DATA_W-1:0]   fill_data,
    cache_refill_ctrl_if.master mem,
    output logic [CNT_W-1:0]    miss_count
);
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    state_t            state;
    logic [ADDR_W-1:0] lat_addr;
    entry_t            push_entry;
    entry_t            head;
    logic              wb_push;
    logic              wb_pop;
    logic              wb_full;
    logic              wb_empty;

    // A simultaneous read wins; the write is ignored.
    assign wb_push    = (state == ST_IDLE) && req_we && !req_re;
    assign push_entry = '{addr: req_addr, data: req_data};
    assign wb_pop     = mem.mem_req_valid && mem.mem_req_we && mem.mem_req_ready;

    wbuf_fifo #(
        .DEPTH   (WBUF_DEPTH),
        .entry_t (entry_t)
    ) u_wbuf (
        .clk   (clk),
        .reset (reset),
        .push  (wb_push),
        .wdata (push_entry),
        .pop   (wb_pop),
        .rdata (head),
        .full  (wb_full),
        .empty (wb_empty)
    );

    assign cpu_stall = (state != ST_IDLE) || wb_full;

    // Single owner of the memory port: the miss read in MISS_REQ, else the buffer head.
    always_comb begin
        mem.mem_req_valid = 1'b0;
        mem.mem_req_we    = 1'b0;
        mem.mem_req_addr  = '0;
        mem.mem_req_wdata = '0;
        if (state == ST_MISS_REQ) begin
            mem.mem_req_valid = 1'b1;
            mem.mem_req_addr  = lat_addr;
        end else if (state != ST_MISS_WAIT && !wb_empty) begin
            mem.mem_req_valid = 1'b1;
            mem.mem_req_we    = 1'b1;
            mem.mem_req_addr  = head.addr;
            mem.mem_req_wdata = head.data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            lat_addr   <= '0;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            fill_we    <= 1'b0;
            fill_addr  <= '0;
            fill_data  <= '0;
            miss_count <= '0;
        end else begin
            cpu_rvalid <= 1'b0;
            fill_we    <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (req_re) begin
                        lat_addr <= req_addr;
                        state    <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (cache_hit) begin
                        cpu_rvalid <= 1'b1;
                        cpu_rdata  <= cache_data;
                        state      <= ST_IDLE;
                    end else begin
                        if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (wb_empty) state <= ST_MISS_REQ;
                end
                ST_MISS_REQ: begin
                    if (mem.mem_req_ready) state <= ST_MISS_WAIT;
                end
                ST_MISS_WAIT: begin
                    if (mem.mem_rsp_valid) begin
                        fill_we    <= 1'b1;
                        fill_addr  <= lat_addr;
                        fill_data  <= mem.mem_rsp_data;
                        cpu_rvalid <= 1'b1;
                        cpu_rdata  <= mem.mem_rsp_data;
                        state      <= ST_FILL;
                    end
                end
                ST_FILL: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
